// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller for the shared PWM: round-robin arbitration of two duty requesters,
// with duty_o updated only on PWM period boundaries. Define PWM_CTRL_SLEW_EN for STEP-limited ramps.
module pwm_duty_ctrl #(
    parameter int DUTY_W = 4,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              period_end_i,
    input  logic              req0_i,
    input  logic [DUTY_W-1:0] duty0_i,
    input  logic              req1_i,
    input  logic [DUTY_W-1:0] duty1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic [DUTY_W-1:0] target_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

`ifdef PWM_CTRL_SLEW_EN
    localparam int STEP_LIM = STEP;
`else
    // Any limit at or above the full duty range makes duty_o jump straight to the target.
    localparam int STEP_LIM = (STEP > (2**DUTY_W - 1)) ? 2**DUTY_W : 2**DUTY_W - 1;
`endif
    localparam logic [DUTY_W:0]   STEP_LIM_W = (DUTY_W+1)'(STEP_LIM);
    localparam logic [DUTY_W-1:0] STEP_LIM_N = DUTY_W'(STEP_LIM);

    state_t            state_reg;
    logic              rr_ptr_reg, rr_ptr_next;
    logic              ack0_reg, ack1_reg;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic [DUTY_W-1:0] target_reg, target_next;
    logic [DUTY_W-1:0] tgt_eff;
    logic [DUTY_W:0]   diff;
    logic [DUTY_W-1:0] step_amt;
    logic [1:0]        req_vec;
    logic [1:0]        grant;

    assign req_vec = {req1_i, req0_i};

    // A lone request always wins; on contention the requester at rr_ptr wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_vec[gi] & (~req_vec[1-gi] | (rr_ptr_reg == 1'(gi)));
        end
    endgenerate

    always_comb begin
        tgt_eff = en_i ? target_reg : '0;

        if (tgt_eff >= duty_reg) begin
            diff = {1'b0, tgt_eff} - {1'b0, duty_reg};
        end else begin
            diff = {1'b0, duty_reg} - {1'b0, tgt_eff};
        end
        step_amt = (diff > STEP_LIM_W) ? STEP_LIM_N : diff[DUTY_W-1:0];

        duty_next = duty_reg;
        if (period_end_i) begin
            if (tgt_eff > duty_reg) begin
                duty_next = duty_reg + step_amt;
            end else begin
                duty_next = duty_reg - step_amt;
            end
        end

        target_next = target_reg;
        rr_ptr_next = rr_ptr_reg;
        if (grant[0]) begin
            target_next = duty0_i;
            rr_ptr_next = 1'b1;
        end else if (grant[1]) begin
            target_next = duty1_i;
            rr_ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            duty_reg   <= '0;
            target_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            ack0_reg   <= grant[0];
            ack1_reg   <= grant[1];
            duty_reg   <= duty_next;
            target_reg <= target_next;
            // State tracks the pre-edge relation between duty_o and the effective target.
            if (duty_reg < tgt_eff) begin
                state_reg <= RAMP_UP;
            end else if (duty_reg > tgt_eff) begin
                state_reg <= RAMP_DOWN;
            end else begin
                state_reg <= IDLE;
            end
        end
    end

    assign ack0_o   = ack0_reg;
    assign ack1_o   = ack1_reg;
    assign duty_o   = duty_reg;
    assign target_o = target_reg;
    assign busy_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: a reference model queues expected state and grants,
// a monitor pops and compares them against the DUT one cycle at a time.
module tb_pwm_duty_ctrl;
    localparam int DW   = 4;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          period_end = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DW-1:0] duty0 = '0;
    logic [DW-1:0] duty1 = '0;
    logic          ack0_o, ack1_o, busy_o;
    logic [DW-1:0] duty_o, target_o;

    pwm_duty_ctrl #(.DUTY_W(DW), .STEP(STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .period_end_i (period_end),
        .req0_i       (req0),
        .duty0_i      (duty0),
        .req1_i       (req1),
        .duty1_i      (duty1),
        .ack0_o       (ack0_o),
        .ack1_o       (ack1_o),
        .duty_o       (duty_o),
        .target_o     (target_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int duty; int target; int busy; } exp_t;
    typedef struct { int cyc; int who; int target; } ack_t;

    exp_t exp_q[$];
    ack_t ack_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pcnt = 0;
    int   mcyc = 0;

    // PWM period: period_end high for one cycle out of every 16.
    initial begin
        forever begin
            @(negedge clk);
            pcnt = (pcnt + 1) % 16;
            period_end = (pcnt == 15);
        end
    end

    // Reference model: duty moves toward the effective target on each period end.
    initial begin
        int m_duty, m_target, m_rr, m_busy, eff, d, win;
        m_duty = 0; m_target = 0; m_rr = 0; m_busy = 0;
        forever begin
            @(posedge clk);
            mcyc++;
            if (rst) begin
                m_duty = 0; m_target = 0; m_rr = 0; m_busy = 0;
            end else begin
                eff = en ? m_target : 0;
                m_busy = (m_duty != eff) ? 1 : 0;
                if (period_end) begin
`ifdef PWM_CTRL_SLEW_EN
                    d = eff - m_duty;
                    if (d > STEP) d = STEP;
                    if (d < -STEP) d = -STEP;
                    m_duty = m_duty + d;
`else
                    m_duty = eff;
`endif
                end
                win = -1;
                if (req0 && req1) win = m_rr;
                else if (req0) win = 0;
                else if (req1) win = 1;
                if (win >= 0) begin
                    m_target = (win == 0) ? int'(duty0) : int'(duty1);
                    m_rr = 1 - win;
                    ack_q.push_back('{mcyc, win, m_target});
                end
            end
            exp_q.push_back('{mcyc, m_duty, m_target, m_busy});
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, mcyc, act, expv);
        end
    endtask

    // Monitor: compare state every cycle, grants whenever the DUT acks.
    initial begin
        exp_t e;
        ack_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL exp_queue_empty cycle=%0d actual=empty expected=entry", mcyc);
            end else begin
                e = exp_q.pop_front();
                chk("duty_o", int'(duty_o), e.duty);
                chk("target_o", int'(target_o), e.target);
                chk("busy_o", int'(busy_o), e.busy);
            end
            if (ack0_o || ack1_o) begin
                if (ack_q.size() == 0 || ack_q[0].cyc != mcyc) begin
                    checks++; errors++;
                    $display("FAIL spurious_ack cycle=%0d actual=ack0:%0b ack1:%0b expected=none",
                             mcyc, ack0_o, ack1_o);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_single", int'(ack0_o && ack1_o), 0);
                    chk("ack_who", ack1_o ? 1 : 0, a.who);
                    chk("ack_target", int'(target_o), a.target);
                    $display("ack%0d target=%0d cycle=%0d", a.who, a.target, mcyc);
                end
            end
            while (ack_q.size() > 0 && ack_q[0].cyc <= mcyc) begin
                a = ack_q.pop_front();
                checks++; errors++;
                $display("FAIL missed_ack cycle=%0d actual=none expected=ack%0d", mcyc, a.who);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int who, input int d);
        int n;
        if (who == 0) begin req0 = 1'b1; duty0 = DW'(d); end
        else begin req1 = 1'b1; duty1 = DW'(d); end
        n = 0;
        while (1) begin
            step();
            if ((who == 0 && ack0_o) || (who == 1 && ack1_o)) break;
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL ack_timeout requester=%0d actual=no_ack expected=ack", who);
                break;
            end
        end
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic both(input int d0, input int d1);
        int n;
        req0 = 1'b1; duty0 = DW'(d0);
        req1 = 1'b1; duty1 = DW'(d1);
        n = 0;
        while (req0 || req1) begin
            step();
            if (ack0_o) req0 = 1'b0;
            if (ack1_o) req1 = 1'b0;
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL both_timeout actual=req0:%0b req1:%0b expected=both_acked", req0, req1);
                req0 = 1'b0; req1 = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_cycles(4);

        request(0, 6);
        wait_cycles(16 * 8);

        both(3, 12);
        wait_cycles(20);
        request(0, 3);
        both(3, 12);
        wait_cycles(16 * 4);

        request(1, 10);
        wait_cycles(16 * 4);
        request(0, 0);
        wait_cycles(16 * 4);
        request(0, 13);
        wait_cycles(16 * 5);
        request(0, 15);
        wait_cycles(16 * 2);

        request(0, 8);
        wait_cycles(16 * 4);
        en = 1'b0;
        wait_cycles(16 * 4);
        en = 1'b1;
        wait_cycles(16 * 4);

        request(0, 4);
        wait_cycles(16 * 3);
        while (pcnt != 15) step();
        request(0, 9);
        wait_cycles(16 * 4);

        request(1, 15);
        wait_cycles(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_cycles(8);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: request(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
                5, 6:          both(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                7:             en = ($urandom_range(0, 3) != 0);
                8: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        step();
                        rst = 1'b0;
                    end
                end
                default: ;
            endcase
            wait_cycles(int'($urandom_range(0, 40)));
        end

        en = 1'b1;
        wait_cycles(16 * 5);
        if (ack_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending_acks actual=%0d expected=0", ack_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
